bin_bcd_seq: RTL and testbench
==============================

BIN_BCD_SEQ -- requirements
Module: bin_bcd_seq

Interface
REQ-001 SHALL provide parameter BIN_W, default 6, binary input width in bits (legal range 1..32).
REQ-002 SHALL provide parameter DIGITS, default 2, number of BCD output digits (legal range 1..10).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL provide port clk  input  1  rising-edge clock.
REQ-005 SHALL provide port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL provide port start  input  1  conversion request, sampled on clk rising edge.
REQ-007 SHALL provide port bin  input  BIN_W  unsigned binary operand, sampled on the edge that accepts start.
REQ-008 SHALL provide port busy  output  1  high while a conversion is in progress.
REQ-009 SHALL provide port done  output  1  single-cycle pulse marking a new result.
REQ-010 SHALL provide port bcd  output  4*DIGITS  packed BCD result; digit 0 is bcd[3:0], the least significant digit.
REQ-011 SHALL provide port ovf  output  1  operand exceeds 10^DIGITS-1; registered and held with bcd.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 SHALL, in IDLE with start=1: capture bin into a shift register, clear the BCD scratch, load the bit counter with BIN_W, and go to SHIFT.
REQ-014 SHALL, in each SHIFT cycle: add 3 to every scratch digit >=5, then shift the scratch left by one with the operand MSB shifted in (double dabble); the bit counter decrements by 1.
REQ-015 SHALL go from SHIFT to DONE after exactly BIN_W SHIFT cycles.
REQ-016 SHALL, in DONE: load bcd and ovf from the scratch and the overflow flag, pulse done for exactly one cycle, and return to IDLE.
REQ-017 SHALL give a fixed latency: when start is accepted at edge k, done is high in the cycle following edge k+BIN_W+1.
REQ-018 SHALL drive busy=1 in SHIFT and DONE, and busy=0 in IDLE.
REQ-019 SHALL ignore start while busy=1; the in-flight conversion and its operand are unaffected.
REQ-020 SHALL hold bcd and ovf stable between done pulses; they change only in the DONE cycle.
REQ-021 SHALL accept a new start in the cycle immediately after done, giving BIN_W+2 cycles per conversion back-to-back.
REQ-022 SHALL size the scratch to hold ceil(BIN_W*log10(2)) digits internally, or DIGITS digits if that is larger, so that no intermediate digit is lost.
REQ-023 SHALL compute the overflow flag at capture as bin > 10^DIGITS-1, using a width-safe constant comparison.
REQ-024 SHALL produce, for operand 0, the result bcd=0, ovf=0, with the normal latency.

Reset
REQ-025 SHALL, while rst=1, immediately force state=IDLE, busy=0, done=0, bcd=0, ovf=0, and clear the scratch and counter.
REQ-026 SHALL, on rst asserted mid-conversion, abort the conversion; no done pulse is issued for it.
REQ-027 SHALL ignore start on the first rising edge after rst deasserts only if rst is still high at that edge; otherwise start is accepted normally.

Configuration
REQ-028 SHALL support macro BCD_SAT_EN.
REQ-029 SHALL, with BCD_SAT_EN defined and overflow set: drive every bcd digit to 4'h9 and ovf=1.
REQ-030 SHALL, with BCD_SAT_EN undefined: output bcd as the low DIGITS digits of the full conversion (truncation), tie ovf to 0, and omit the overflow comparator.

Verification
REQ-031 SHALL cover, with defaults: start with bin=59 -> done 7 cycles later, bcd=8'h59, ovf=0, busy high for 7 cycles.
REQ-032 SHALL cover, with defaults: bin=0, then bin=63 back-to-back -> bcd=8'h00, then bcd=8'h63 on consecutive done pulses 8 cycles apart.
REQ-033 SHALL cover, with DIGITS=1, BIN_W=6, bin=42: BCD_SAT_EN defined -> bcd=4'h9, ovf=1; BCD_SAT_EN undefined -> bcd=4'h2, ovf=0.
REQ-034 SHALL cover: start with bin=25, then start pulsed with bin=10 during SHIFT -> single done, bcd=8'h25; the second request is ignored.
REQ-035 SHALL cover: rst asserted 3 cycles into a conversion -> outputs zero immediately; no done; the next start with bin=17 yields bcd=8'h17.
REQ-036 SHALL cover, with BIN_W=16, DIGITS=5, bin=65535: done after 17 cycles, bcd=20'h65535, ovf=0.

Source files
------------

// File: rtl/bin_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per cycle.
// Optional macro BCD_SAT_EN: saturate to all-9s and flag ovf when operand > 10^DIGITS-1.
module bin_bcd_seq #(
  parameter int BIN_W  = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  // Decimal digit count of the largest BIN_W-bit operand.
  function automatic int bin_digits(input int w);
    logic [63:0] v;
    int          n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    for (int i = 0; i < 20; i++)
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n++;
      end
    return n;
  endfunction

  localparam int NAT = bin_digits(BIN_W);
  localparam int SD  = (NAT > DIGITS) ? NAT : DIGITS;
  localparam int SW  = 4 * SD;
  localparam int CW  = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [BIN_W-1:0]      opnd_q, opnd_d;
  logic [SW-1:0]         scr_q, scr_d, scr_adj;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;

`ifdef BCD_SAT_EN
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_V = pow10(DIGITS) - 64'd1;

  logic ovf_flag_q, ovf_flag_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < SD; i++)
      if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    opnd_d = opnd_q;
    scr_d  = scr_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    done_d = 1'b0;
`ifdef BCD_SAT_EN
    ovf_flag_d = ovf_flag_q;
    ovf_d      = ovf_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        opnd_d = bin;
        scr_d  = '0;
        cnt_d  = CW'(BIN_W);
`ifdef BCD_SAT_EN
        ovf_flag_d = (64'(bin) > MAX_V);
`endif
      end
      SHIFT: begin
        scr_d  = (scr_adj << 1) | SW'(opnd_q[BIN_W-1]);
        opnd_d = opnd_q << 1;
        cnt_d  = cnt_q - CW'(1);
      end
      DONE: begin
        done_d = 1'b1;
`ifdef BCD_SAT_EN
        ovf_d = ovf_flag_q;
        bcd_d = ovf_flag_q ? {DIGITS{4'h9}} : scr_q[4*DIGITS-1:0];
`else
        bcd_d = scr_q[4*DIGITS-1:0];
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
`ifdef BCD_SAT_EN
      ovf_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
`ifdef BCD_SAT_EN
      ovf_flag_q <= ovf_flag_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    bcd  = bcd_q;
`ifdef BCD_SAT_EN
    ovf  = ovf_q;
`else
    ovf  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Scoreboard bench for bin_bcd_seq: directed vectors on three parameterizations.
module tb_bin_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        st0, st1, st2;
  logic [5:0]  b0, b2;
  logic [15:0] b1;
  logic        busy0, done0, ovf0;
  logic        busy1, done1, ovf1;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd0;
  logic [19:0] bcd1;
  logic [3:0]  bcd2;

  bin_bcd_seq #(.BIN_W(6), .DIGITS(2)) dut0 (
    .clk(clk), .rst(rst), .start(st0), .bin(b0),
    .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0));
  bin_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .bin(b1),
    .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1));
  bin_bcd_seq #(.BIN_W(6), .DIGITS(1)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .bin(b2),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2));

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [7:0]  last0 = '0;
  logic [19:0] last1 = '0;
  logic [3:0]  last2 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic hold_fail(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    failures++;
    $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
  endtask

  // Monitors: pop and compare on every done pulse; bcd must not move otherwise.
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) hold_fail("dut0_unexpected_done", 32'(bcd0), 32'hFFFF_FFFF);
      else begin
        e0 = q0.pop_front();
        chk("dut0_bcd", 32'(bcd0), 32'(e0.bcd));
        chk("dut0_ovf", 32'(ovf0), 32'(e0.ovf));
        chk("dut0_latency", 32'(cyc), 32'(e0.cyc));
      end
    end else if (!rst && bcd0 !== last0) hold_fail("dut0_bcd_hold", 32'(bcd0), 32'(last0));
    last0 = bcd0;
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) hold_fail("dut1_unexpected_done", 32'(bcd1), 32'hFFFF_FFFF);
      else begin
        e1 = q1.pop_front();
        chk("dut1_bcd", 32'(bcd1), 32'(e1.bcd));
        chk("dut1_ovf", 32'(ovf1), 32'(e1.ovf));
        chk("dut1_latency", 32'(cyc), 32'(e1.cyc));
      end
    end else if (!rst && bcd1 !== last1) hold_fail("dut1_bcd_hold", 32'(bcd1), 32'(last1));
    last1 = bcd1;
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) hold_fail("dut2_unexpected_done", 32'(bcd2), 32'hFFFF_FFFF);
      else begin
        e2 = q2.pop_front();
        chk("dut2_bcd", 32'(bcd2), 32'(e2.bcd));
        chk("dut2_ovf", 32'(ovf2), 32'(e2.ovf));
        chk("dut2_latency", 32'(cyc), 32'(e2.cyc));
      end
    end else if (!rst && bcd2 !== last2) hold_fail("dut2_bcd_hold", 32'(bcd2), 32'(last2));
    last2 = bcd2;
  end

  // Issue tasks: called at a negedge; done expected BIN_W+2 negedges later.
  task automatic go0(input logic [5:0] v, input logic [7:0] e);
    exp_t x;
    x.bcd = 20'(e); x.ovf = 1'b0; x.cyc = cyc + 8;
    q0.push_back(x);
    st0 = 1'b1; b0 = v;
    @(negedge clk);
    st0 = 1'b0;
  endtask

  task automatic go1(input logic [15:0] v, input logic [19:0] e);
    exp_t x;
    x.bcd = e; x.ovf = 1'b0; x.cyc = cyc + 18;
    q1.push_back(x);
    st1 = 1'b1; b1 = v;
    @(negedge clk);
    st1 = 1'b0;
  endtask

  task automatic go2(input logic [5:0] v, input logic [3:0] e, input logic o);
    exp_t x;
    x.bcd = 20'(e); x.ovf = o; x.cyc = cyc + 8;
    q2.push_back(x);
    st2 = 1'b1; b2 = v;
    @(negedge clk);
    st2 = 1'b0;
  endtask

  logic [5:0] tv [4] = '{6'd37, 6'd9, 6'd10, 6'd50};
  logic [7:0] te [4] = '{8'h37, 8'h09, 8'h10, 8'h50};

  initial begin
    int n;
    st0 = 0; st1 = 0; st2 = 0; b0 = '0; b1 = '0; b2 = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_done", 32'(done0), 32'd0);
    chk("reset_bcd", 32'(bcd0), 32'd0);
    chk("reset_ovf", 32'(ovf0), 32'd0);
    chk("reset_bcd_w16", 32'(bcd1), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 59: busy for 7 cycles, done right after
    go0(6'd59, 8'h59);
    n = 0;
    while (busy0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("dut0_busy_cycles", 32'(n), 32'd7);

    // back-to-back 0 then 63, 8 cycles apart
    go0(6'd0, 8'h00);
    repeat (7) @(negedge clk);
    go0(6'd63, 8'h63);
    repeat (7) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      go0(tv[i], te[i]);
      repeat (7) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // start pulsed during SHIFT is ignored
    go0(6'd25, 8'h25);
    repeat (2) @(negedge clk);
    st0 = 1'b1; b0 = 6'd10;
    @(negedge clk);
    st0 = 1'b0;
    repeat (10) @(negedge clk);

    go1(16'd65535, 20'h65535);
`ifdef BCD_SAT_EN
    go2(6'd42, 4'h9, 1'b1);
`else
    go2(6'd42, 4'h2, 1'b0);
`endif
    repeat (22) @(negedge clk);

    // reset 3 cycles into a conversion: no done, outputs cleared at once
    st0 = 1'b1; b0 = 6'd33;
    @(negedge clk);
    st0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy_before", 32'(busy0), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_bcd", 32'(bcd0), 32'd0);
    chk("abort_ovf", 32'(ovf0), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    go0(6'd17, 8'h17);

    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
